// File: rtl/echo_processor.sv
// echo_processor: recirculating echo stage between the ADC and DAC paths.
// Each accepted sample x[n] produces y[n] = sat(x[n] + (y[n-D] >>> GAIN_SHIFT)),
// with y[] kept in a circular delay RAM indexed by a free-running write pointer.
module echo_processor #(
    parameter int ADDR_W     = 13,
    parameter int GAIN_SHIFT = 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [9:0]        data_in,
    input  logic [ADDR_W-1:0] delay,
    output logic [9:0]        data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_CALC, S_WR} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};

    state_t                    state_q, state_d;
    logic signed [9:0]         x_q;
    logic [ADDR_W-1:0]         dl_q;
    logic [ADDR_W-1:0]         raddr_q;
    logic [ADDR_W-1:0]         wr_ptr_q;
    logic [ADDR_W-1:0]         fill_q;
    logic [9:0]                fb_raw_q;
    logic signed [9:0]         y_q;
    logic [9:0]                data_out_q;
    logic                      out_valid_q;
    logic                      overrun_q;

    // Delay line: one sample per address, holds signed y values (not reset).
    logic [9:0] mem [0:(2**ADDR_W)-1];

    logic signed [9:0]  fb;
    logic signed [9:0]  fb_sh;
    logic signed [10:0] sum;
    logic signed [9:0]  y_sat;

    // Next-state logic: one cycle per stage once a sample is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (data_valid) state_d = S_RD;
            S_RD:    state_d = S_CALC;
            S_CALC:  state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Feedback gating, scaling and symmetric saturation of the echo sum.
    always_comb begin
        // History older than what has been written since reset is never fed back.
        fb    = ((dl_q != '0) && (fill_q >= dl_q)) ? $signed(fb_raw_q) : 10'sd0;
        fb_sh = fb >>> GAIN_SHIFT;
        sum   = 11'(x_q) + 11'(fb_sh);
        if (sum > 11'sd511)
            y_sat = 10'sd511;
        else if (sum < -11'sd512)
            y_sat = -10'sd512;
        else
            y_sat = sum[9:0];
    end

    // Delay RAM: synchronous read in RD, write of the finished sample in WR.
    always_ff @(posedge sysclk) begin
        if (state_q == S_RD)
            fb_raw_q <= mem[raddr_q];
        if (state_q == S_WR)
            mem[wr_ptr_q] <= y_q;
    end

    // Pipeline registers, pointers, output strobe and sticky overrun flag.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            dl_q        <= '0;
            raddr_q     <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            y_q         <= '0;
            data_out_q  <= 10'd512;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_q == S_WR);
            // Any strobe outside IDLE (including the WR cycle) is dropped.
            if (data_valid && (state_q != S_IDLE))
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (data_valid) begin
                        x_q     <= {~data_in[9], data_in[8:0]};
                        dl_q    <= delay;
                        raddr_q <= wr_ptr_q - delay;
                    end
                end
                S_CALC: y_q <= y_sat;
                S_WR: begin
                    data_out_q <= {~y_q[9], y_q[8:0]};
                    wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                    if (fill_q != FILL_MAX)
                        fill_q <= fill_q + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_processor.sv
// Self-checking bench for echo_processor: randomized and directed samples
// compared against a sample-history model of the echo recurrence.
`timescale 1ns/1ps
module tb_echo_processor;

    localparam int ADDR_W = 13;
    localparam int GS     = 1;

    logic              sysclk = 1'b0;
    logic              rst;
    logic              data_valid;
    logic [9:0]        data_in;
    logic [ADDR_W-1:0] delay;
    logic [9:0]        data_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int errors = 0;
    int checks = 0;
    int hist[$];   // signed y values produced since the last reset

    always #10 sysclk = ~sysclk;

    echo_processor #(.ADDR_W(ADDR_W), .GAIN_SHIFT(GS)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay      (delay),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Reference: y[n] = clamp(x[n] + floor(y[n-D] / 2**GS)); no echo until D outputs exist.
    function automatic int ref_step(input int din, input int d);
        int x, fb, half, s, y;
        x  = din - 512;
        fb = (d != 0 && hist.size() >= d) ? hist[hist.size() - d] : 0;
        if (fb >= 0) half = fb / (1 << GS);
        else         half = -((-fb + (1 << GS) - 1) / (1 << GS));
        s = x + half;
        y = (s > 511) ? 511 : ((s < -512) ? -512 : s);
        hist.push_back(y);
        return y + 512;
    endfunction

    // Stimulus only: strobe one sample, then watch 8 cycles. Optionally pulse an
    // extra (to-be-dropped) strobe at watch cycle extra_at.
    task automatic drive_sample(input logic [9:0] din, input logic [ADDR_W-1:0] d,
                                input int extra_at, output logic [9:0] dout,
                                output int lat, output int nvalid, output int nbusy);
        @(negedge sysclk);
        data_in = din; delay = d; data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        lat = -1; nvalid = 0; nbusy = 0; dout = data_out;
        for (int i = 0; i < 8; i++) begin
            if (busy) nbusy++;
            if (out_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat  = i;
                    dout = data_out;
                end
            end
            data_valid = (i == extra_at);
            if (i == extra_at) data_in = ~din;
            @(negedge sysclk);
        end
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b0; data_in = '0; delay = '0;
        #5;
        checks++; if (data_out !== 10'd512) begin errors++; $display("FAIL reset_data_out: got %0d expected 512", data_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        $display("reset: data_out=%0d out_valid=%b busy=%b overrun=%b", data_out, out_valid, busy, overrun);
        @(negedge sysclk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic test_bypass();
        logic [9:0] dout; int lat, nv, nb, exp;
        do_reset();
        exp = ref_step(700, 0);
        drive_sample(10'd700, '0, -1, dout, lat, nv, nb);
        $display("bypass: din=700 dout=%0d lat=%0d valid=%0d busy=%0d", dout, lat, nv, nb);
        checks++; if (dout !== 10'(exp)) begin errors++; $display("FAIL bypass_data: got %0d expected %0d", dout, exp); end
        checks++; if (lat != 3) begin errors++; $display("FAIL bypass_latency: got %0d expected 3", lat); end
        checks++; if (nv != 1) begin errors++; $display("FAIL bypass_valid_count: got %0d expected 1", nv); end
        checks++; if (nb != 3) begin errors++; $display("FAIL bypass_busy_cycles: got %0d expected 3", nb); end
    endtask

    task automatic test_impulse();
        logic [9:0] dout; int lat, nv, nb, exp, din;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            din = (k == 0) ? 768 : 512;
            exp = ref_step(din, 4);
            drive_sample(10'(din), 13'd4, -1, dout, lat, nv, nb);
            $display("impulse[%0d]: din=%0d dout=%0d exp=%0d", k, din, dout, exp);
            checks++; if (dout !== 10'(exp) || nv != 1) begin errors++; $display("FAIL impulse_%0d: got %0d/%0d expected %0d/1", k, dout, nv, exp); end
        end
    endtask

    task automatic test_saturation();
        logic [9:0] dout; int lat, nv, nb, exp;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int k = 0; k < 3; k++) begin
                exp = ref_step(pass == 0 ? 1023 : 0, 1);
                drive_sample(pass == 0 ? 10'd1023 : 10'd0, 13'd1, -1, dout, lat, nv, nb);
                $display("saturation[%0d/%0d]: dout=%0d exp=%0d", pass, k, dout, exp);
                checks++; if (dout !== 10'(exp)) begin errors++; $display("FAIL saturation_%0d_%0d: got %0d expected %0d", pass, k, dout, exp); end
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] dout; int lat, nv, nb, exp, din, d;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            d = $urandom_range(0, 12);
            case ($urandom_range(0, 9))
                0:       din = 0;
                1:       din = 1023;
                default: din = $urandom_range(0, 1023);
            endcase
            exp = ref_step(din, d);
            drive_sample(10'(din), 13'(d), -1, dout, lat, nv, nb);
            $display("random[%0d]: din=%0d delay=%0d dout=%0d exp=%0d", k, din, d, dout, exp);
            checks++; if (dout !== 10'(exp) || lat != 3) begin errors++; $display("FAIL random_%0d: got %0d lat %0d expected %0d lat 3", k, dout, lat, exp); end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL random_no_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        logic [9:0] dout; int lat, nv, nb, exp;
        do_reset();
        exp = ref_step(600, 3);
        drive_sample(10'd600, 13'd3, 0, dout, lat, nv, nb);
        $display("overrun_rd: dout=%0d exp=%0d valid=%0d overrun=%b", dout, exp, nv, overrun);
        checks++; if (nv != 1 || dout !== 10'(exp)) begin errors++; $display("FAIL overrun_rd_drop: got %0d/%0d expected %0d/1", dout, nv, exp); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        exp = ref_step(300, 3);
        drive_sample(10'd300, 13'd3, -1, dout, lat, nv, nb);
        $display("overrun_next: dout=%0d exp=%0d overrun=%b", dout, exp, overrun);
        checks++; if (dout !== 10'(exp) || nv != 1) begin errors++; $display("FAIL overrun_next_sample: got %0d expected %0d", dout, exp); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        exp = ref_step(450, 3);
        drive_sample(10'd450, 13'd3, 2, dout, lat, nv, nb);
        $display("overrun_wr: dout=%0d exp=%0d valid=%0d", dout, exp, nv);
        checks++; if (nv != 1 || dout !== 10'(exp)) begin errors++; $display("FAIL overrun_wr_drop: got %0d/%0d expected %0d/1", dout, nv, exp); end
        exp = ref_step(512, 3);
        drive_sample(10'd512, 13'd3, -1, dout, lat, nv, nb);
        $display("overrun_after_wr: dout=%0d exp=%0d", dout, exp);
        checks++; if (dout !== 10'(exp)) begin errors++; $display("FAIL overrun_after_wr: got %0d expected %0d", dout, exp); end
        do_reset();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_midop();
        logic [9:0] dout; int lat, nv, nb, exp, din, seen;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp = ref_step(1000, 4);
            drive_sample(10'd1000, 13'd4, -1, dout, lat, nv, nb);
            checks++; if (dout !== 10'(exp)) begin errors++; $display("FAIL midop_pre_%0d: got %0d expected %0d", k, dout, exp); end
        end
        @(negedge sysclk);
        data_in = 10'd900; delay = 13'd4; data_valid = 1'b1;
        @(negedge sysclk);   // now in RD
        data_valid = 1'b0;
        @(negedge sysclk);   // now in CALC
        rst = 1'b1;
        #1;
        checks++; if (data_out !== 10'd512 || busy !== 1'b0) begin errors++; $display("FAIL midop_reset_values: got %0d busy %b expected 512 busy 0", data_out, busy); end
        @(negedge sysclk);
        rst = 1'b0;
        hist.delete();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen++;
            @(negedge sysclk);
        end
        $display("midop: out_valid seen=%0d data_out=%0d", seen, data_out);
        checks++; if (seen != 0 || data_out !== 10'd512) begin errors++; $display("FAIL midop_no_output: got %0d strobes data_out %0d expected 0 and 512", seen, data_out); end
        for (int k = 0; k < 9; k++) begin
            din = (k == 0) ? 768 : 512;
            exp = ref_step(din, 4);
            drive_sample(10'(din), 13'd4, -1, dout, lat, nv, nb);
            $display("midop_post[%0d]: din=%0d dout=%0d exp=%0d", k, din, dout, exp);
            checks++; if (dout !== 10'(exp)) begin errors++; $display("FAIL midop_post_%0d: got %0d expected %0d", k, dout, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_impulse();
        test_saturation();
        test_random();
        test_overrun();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
